// File: rtl/packet_crossbar.sv
// AXI-Stream packet crossbar: per-egress round-robin arbitration with whole-packet grants,
// drop of packets to masked egresses, and an 8-bit Avalon-MM register block with drop counters.
module packet_crossbar #(
    parameter  int NUM_INGRESS = 4,
    parameter  int NUM_EGRESS  = 4,
    parameter  int DATA_WIDTH  = 16,
    localparam int DEST_WIDTH  = $clog2(NUM_EGRESS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              chipselect,
    input  logic                              write,
    input  logic                              read,
    input  logic [7:0]                        address,
    input  logic [7:0]                        writedata,
    output logic [7:0]                        readdata,
    input  logic [NUM_INGRESS*DATA_WIDTH-1:0] ingress_tdata,
    input  logic [NUM_INGRESS*DEST_WIDTH-1:0] ingress_tdest,
    input  logic [NUM_INGRESS-1:0]            ingress_tvalid,
    input  logic [NUM_INGRESS-1:0]            ingress_tlast,
    output logic [NUM_INGRESS-1:0]            ingress_tready,
    output logic [NUM_EGRESS*DATA_WIDTH-1:0]  egress_tdata,
    output logic [NUM_EGRESS-1:0]             egress_tvalid,
    output logic [NUM_EGRESS-1:0]             egress_tlast,
    input  logic [NUM_EGRESS-1:0]             egress_tready,
    output logic                              irq
);
    localparam int GW = $clog2(NUM_INGRESS);

    typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_t;

    state_t                r_state [NUM_EGRESS];
    logic [GW-1:0]         r_gnt   [NUM_EGRESS];
    logic [GW-1:0]         r_ptr   [NUM_EGRESS];
    logic [7:0]            r_cnt   [NUM_EGRESS];
    logic [NUM_EGRESS-1:0] r_mask;
    logic [NUM_EGRESS-1:0] r_irq_en;
    logic [NUM_EGRESS-1:0] r_status;

    logic [DATA_WIDTH-1:0]  w_in_data [NUM_INGRESS];
    logic [DEST_WIDTH-1:0]  w_in_dest [NUM_INGRESS];
    logic [NUM_INGRESS-1:0] w_req     [NUM_EGRESS];
    logic [NUM_INGRESS-1:0] w_rdy_e   [NUM_EGRESS];
    logic [DATA_WIDTH-1:0]  w_eg_data [NUM_EGRESS];
    logic [GW-1:0]          w_pick    [NUM_EGRESS];
    logic [NUM_EGRESS-1:0]  w_req_any;
    logic [NUM_EGRESS-1:0]  w_fwd_end;
    logic [NUM_EGRESS-1:0]  w_drop_end;
    logic [NUM_EGRESS-1:0]  w_cnt_clr;
    logic [NUM_EGRESS-1:0]  w_w1c;
    logic [NUM_INGRESS-1:0] w_rdy;
    logic [7:0]             w_rdata;
    logic                   w_wr;
    logic                   w_rd;

    for (genvar i = 0; i < NUM_INGRESS; i++) begin : g_in
        assign w_in_data[i] = ingress_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_in_dest[i] = ingress_tdest[i*DEST_WIDTH +: DEST_WIDTH];
    end

    for (genvar e = 0; e < NUM_EGRESS; e++) begin : g_eg
        logic w_is_fwd;
        logic w_is_drop;
        logic w_gvalid;
        logic w_glast;

        for (genvar i = 0; i < NUM_INGRESS; i++) begin : g_req
            assign w_req[e][i] = ingress_tvalid[i] && (w_in_dest[i] == DEST_WIDTH'(e));
        end

        assign w_is_fwd   = (r_state[e] == ST_FWD);
        assign w_is_drop  = (r_state[e] == ST_DROP);
        assign w_gvalid   = ingress_tvalid[r_gnt[e]];
        assign w_glast    = ingress_tlast[r_gnt[e]];

        assign w_eg_data[e]     = w_is_fwd ? w_in_data[r_gnt[e]] : '0;
        assign egress_tdata[e*DATA_WIDTH +: DATA_WIDTH] = w_eg_data[e];
        assign egress_tvalid[e] = w_is_fwd & w_gvalid;
        assign egress_tlast[e]  = w_is_fwd & w_gvalid & w_glast;

        // A dropping egress sinks beats unconditionally; a forwarding one follows downstream ready.
        assign w_rdy_e[e] = (w_is_drop || (w_is_fwd && egress_tready[e]))
                          ? (NUM_INGRESS'(1) << r_gnt[e]) : '0;

        assign w_fwd_end[e]  = w_is_fwd & w_gvalid & egress_tready[e] & w_glast;
        assign w_drop_end[e] = w_is_drop & w_gvalid & w_glast;
    end

    always_comb begin
        w_rdy = '0;
        for (int e = 0; e < NUM_EGRESS; e++) begin
            w_rdy = w_rdy | w_rdy_e[e];
        end
    end
    assign ingress_tready = w_rdy;

    // Round-robin search: scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        int idx;
        idx = 0;
        for (int e = 0; e < NUM_EGRESS; e++) begin
            w_req_any[e] = 1'b0;
            w_pick[e]    = '0;
            for (int k = NUM_INGRESS - 1; k >= 0; k--) begin
                idx = int'(r_ptr[e]) + k;
                if (idx >= NUM_INGRESS) begin
                    idx = idx - NUM_INGRESS;
                end
                if (w_req[e][GW'(idx)]) begin
                    w_req_any[e] = 1'b1;
                    w_pick[e]    = GW'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < NUM_EGRESS; e++) begin
                r_state[e] <= ST_IDLE;
                r_gnt[e]   <= '0;
                r_ptr[e]   <= '0;
            end
        end else begin
            for (int e = 0; e < NUM_EGRESS; e++) begin
                case (r_state[e])
                    ST_IDLE: begin
                        if (w_req_any[e]) begin
                            r_gnt[e]   <= w_pick[e];
                            r_state[e] <= r_mask[e] ? ST_FWD : ST_DROP;
                        end
                    end
                    ST_FWD, ST_DROP: begin
                        if (w_fwd_end[e] || w_drop_end[e]) begin
                            r_state[e] <= ST_IDLE;
                            r_ptr[e]   <= (r_gnt[e] == GW'(NUM_INGRESS - 1)) ? '0 : r_gnt[e] + GW'(1);
                        end
                    end
                    default: r_state[e] <= ST_IDLE;
                endcase
            end
        end
    end

    assign w_wr = chipselect & write;
    assign w_rd = chipselect & read;
    assign w_w1c = (w_wr && address == 8'h02) ? writedata[NUM_EGRESS-1:0] : '0;

    always_comb begin
        w_rdata = '0;
        case (address)
            8'h00:   w_rdata[NUM_EGRESS-1:0] = r_mask;
            8'h01:   w_rdata[NUM_EGRESS-1:0] = r_irq_en;
            8'h02:   w_rdata[NUM_EGRESS-1:0] = r_status;
            default: w_rdata = '0;
        endcase
        for (int e = 0; e < NUM_EGRESS; e++) begin
            w_cnt_clr[e] = w_wr && (address == 8'(16 + e));
            if (address == 8'(16 + e)) begin
                w_rdata = r_cnt[e];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask   <= '1;
            r_irq_en <= '0;
            r_status <= '0;
            readdata <= '0;
            for (int e = 0; e < NUM_EGRESS; e++) begin
                r_cnt[e] <= '0;
            end
        end else begin
            if (w_wr && address == 8'h00) begin
                r_mask <= writedata[NUM_EGRESS-1:0];
            end
            if (w_wr && address == 8'h01) begin
                r_irq_en <= writedata[NUM_EGRESS-1:0];
            end
            // New drops win over a simultaneous write-1-to-clear.
            r_status <= (r_status & ~w_w1c) | w_drop_end;
            for (int e = 0; e < NUM_EGRESS; e++) begin
                if (w_cnt_clr[e]) begin
                    r_cnt[e] <= '0;
                end else if (w_drop_end[e] && r_cnt[e] != 8'hFF) begin
                    r_cnt[e] <= r_cnt[e] + 8'd1;
                end
            end
            if (w_rd) begin
                readdata <= w_rdata;
            end
        end
    end

    assign irq = |(r_status & r_irq_en);

endmodule

// File: tb/tb_packet_crossbar.sv
// Scoreboard bench for packet_crossbar: per-ingress beat queues feed the DUT, per-egress
// expected queues are filled at stimulus time and drained by the egress monitor.
module tb_packet_crossbar;
    localparam int NI    = 4;
    localparam int NE    = 4;
    localparam int DW    = 16;
    localparam int DESTW = 2;

    typedef struct packed {
        logic [DW-1:0]    d;
        logic [DESTW-1:0] dest;
        logic             l;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              chipselect, write, read;
    logic [7:0]        address, writedata;
    logic [7:0]        readdata;
    logic [NI*DW-1:0]  ingress_tdata;
    logic [NI*DESTW-1:0] ingress_tdest;
    logic [NI-1:0]     ingress_tvalid, ingress_tlast, ingress_tready;
    logic [NE*DW-1:0]  egress_tdata;
    logic [NE-1:0]     egress_tvalid, egress_tlast, egress_tready;
    logic              irq;

    beat_t       in_q  [NI][$];
    logic [16:0] exp_q [NE][$];
    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    int          beats   [NE];
    int          first_t [NE];
    int          last_t  [NE];
    int          acc_cnt [NI];
    int          drv_t   [NI];

    packet_crossbar #(.NUM_INGRESS(NI), .NUM_EGRESS(NE), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata),
        .ingress_tdata(ingress_tdata), .ingress_tdest(ingress_tdest),
        .ingress_tvalid(ingress_tvalid), .ingress_tlast(ingress_tlast),
        .ingress_tready(ingress_tready), .egress_tdata(egress_tdata),
        .egress_tvalid(egress_tvalid), .egress_tlast(egress_tlast),
        .egress_tready(egress_tready), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int i = 0; i < NI; i++) s += in_q[i].size();
        for (int e = 0; e < NE; e++) s += exp_q[e].size();
        return s;
    endfunction

    task automatic send_pkt(input int src, input int dst, input int n,
                            input logic [15:0] base, input logic [15:0] step, input bit fwd);
        beat_t bt;
        for (int b = 0; b < n; b++) begin
            bt.d    = base + step * 16'(b);
            bt.dest = DESTW'(dst);
            bt.l    = (b == n - 1);
            in_q[src].push_back(bt);
            if (fwd) exp_q[dst].push_back({bt.l, bt.d});
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (pending() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        check_eq("drain", pending(), 0);
    endtask

    task automatic clear_stats();
        for (int e = 0; e < NE; e++) begin
            beats[e] = 0; first_t[e] = 0; last_t[e] = 0;
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    // Ingress driver and egress monitor share one per-cycle loop.
    initial begin : drv
        logic [NI-1:0] acc;
        logic [16:0]   x;
        ingress_tvalid = '0; ingress_tlast = '0; ingress_tdata = '0; ingress_tdest = '0;
        for (int i = 0; i < NI; i++) begin acc_cnt[i] = 0; drv_t[i] = 0; end
        forever begin
            @(negedge clk);
            acc = ingress_tvalid & ingress_tready;
            for (int i = 0; i < NI; i++) if (acc[i]) acc_cnt[i]++;
            for (int e = 0; e < NE; e++) begin
                if (egress_tvalid[e] && egress_tready[e]) begin
                    if (beats[e] == 0) first_t[e] = cyc;
                    last_t[e] = cyc;
                    beats[e]++;
                    if (exp_q[e].size() == 0) begin
                        check_eq($sformatf("eg%0d_spurious_vld", e), egress_tvalid[e], 1'b0);
                    end else begin
                        x = exp_q[e].pop_front();
                        check_eq($sformatf("eg%0d_data", e), egress_tdata[e*DW +: DW], x[15:0]);
                        check_eq($sformatf("eg%0d_last", e), egress_tlast[e], x[16]);
                    end
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < NI; i++) begin
                if (acc[i] && in_q[i].size() > 0) void'(in_q[i].pop_front());
                if (in_q[i].size() > 0) begin
                    if (!ingress_tvalid[i]) drv_t[i] = cyc;
                    ingress_tvalid[i] = 1'b1;
                    ingress_tlast[i]  = in_q[i][0].l;
                    ingress_tdata[i*DW +: DW]       = in_q[i][0].d;
                    ingress_tdest[i*DESTW +: DESTW] = in_q[i][0].dest;
                end else begin
                    ingress_tvalid[i] = 1'b0;
                    ingress_tlast[i]  = 1'b0;
                end
            end
        end
    end

    initial begin : main
        logic [7:0] rd;
        int base_acc;
        int n;
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; egress_tready = '1;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_eg_tvalid", egress_tvalid, 4'h0);
        check_eq("rst_in_tready", ingress_tready, 4'h0);
        check_eq("rst_readdata", readdata, 8'h00);
        check_eq("rst_irq", irq, 1'b0);
        @(negedge clk); reset = 1'b0;
        bus_read(8'h00, rd); check_eq("rst_mask", rd, 8'h0F);
        bus_read(8'h01, rd); check_eq("rst_irq_en", rd, 8'h00);
        bus_read(8'h02, rd); check_eq("rst_status", rd, 8'h00);

        // Single packet forwarding plus a single-beat packet on another egress.
        clear_stats();
        send_pkt(0, 2, 3, 16'h1111, 16'h1111, 1'b1);
        send_pkt(3, 3, 1, 16'hBEEF, 16'h0000, 1'b1);
        wait_idle(50);
        check_eq("t1_beats", beats[2], 3);
        check_eq("t1_latency", first_t[2] - drv_t[0], 1);
        check_eq("t1_single_beats", beats[3], 1);

        // Three ingresses contend for egress 1; round-robin order 0,1,3,0,1,3.
        clear_stats();
        send_pkt(0, 1, 2, 16'h0100, 16'h0001, 1'b1);
        send_pkt(1, 1, 2, 16'h1100, 16'h0001, 1'b1);
        send_pkt(3, 1, 2, 16'h3100, 16'h0001, 1'b1);
        send_pkt(0, 1, 2, 16'h0200, 16'h0001, 1'b1);
        send_pkt(1, 1, 2, 16'h1200, 16'h0001, 1'b1);
        send_pkt(3, 1, 2, 16'h3200, 16'h0001, 1'b1);
        wait_idle(100);
        check_eq("t2_beats", beats[1], 12);
        check_eq("t2_span", last_t[1] - first_t[1], 16);

        // Disabled egress drops packets and raises the drop interrupt.
        bus_write(8'h00, 8'h0B);
        bus_write(8'h01, 8'h04);
        bus_read(8'h01, rd); check_eq("t3_irq_en", rd, 8'h04);
        base_acc = acc_cnt[0];
        clear_stats();
        send_pkt(0, 2, 2, 16'hD000, 16'h0001, 1'b0);
        send_pkt(0, 2, 2, 16'hD100, 16'h0001, 1'b0);
        wait_idle(50);
        check_eq("t3_drop_accepted", acc_cnt[0] - base_acc, 4);
        check_eq("t3_eg2_beats", beats[2], 0);
        bus_read(8'h12, rd); check_eq("t3_cnt2", rd, 8'h02);
        bus_read(8'h02, rd); check_eq("t3_status", rd, 8'h04);
        check_eq("t3_irq_set", irq, 1'b1);
        bus_write(8'h02, 8'h04);
        check_eq("t3_irq_clr", irq, 1'b0);
        bus_write(8'h05, 8'hFF);
        bus_read(8'h05, rd); check_eq("t3_unmapped", rd, 8'h00);
        bus_write(8'h00, 8'h0F);
        bus_write(8'h01, 8'h00);

        // Backpressure on egress 0 while egress 3 runs in parallel.
        clear_stats();
        send_pkt(1, 0, 4, 16'hA000, 16'h0001, 1'b1);
        send_pkt(2, 3, 4, 16'hC000, 16'h0001, 1'b1);
        n = 0;
        while (beats[0] < 2 && n < 50) begin @(posedge clk); n++; end
        #1; egress_tready[0] = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_eq("t4_stall_q", exp_q[0].size(), 2);
            if (exp_q[0].size() > 0)
                check_eq("t4_stall_data", egress_tdata[DW-1:0], exp_q[0][0][15:0]);
            check_eq("t4_stall_vld", egress_tvalid[0], 1'b1);
            check_eq("t4_stall_rdy", ingress_tready[1], 1'b0);
        end
        check_eq("t4_parallel_done", exp_q[3].size(), 0);
        @(posedge clk); #1; egress_tready[0] = 1'b1;
        wait_idle(50);
        check_eq("t4_eg0_beats", beats[0], 4);

        // Counter saturation with single-beat drops.
        bus_write(8'h00, 8'h0D);
        for (int p = 0; p < 300; p++) send_pkt(0, 1, 1, 16'(p), 16'h0000, 1'b0);
        wait_idle(1500);
        bus_read(8'h11, rd); check_eq("t5_cnt_sat", rd, 8'hFF);
        bus_write(8'h11, 8'h5A);
        bus_read(8'h11, rd); check_eq("t5_cnt_clr", rd, 8'h00);
        bus_write(8'h02, 8'h0F);
        bus_read(8'h02, rd); check_eq("t5_status_clr", rd, 8'h00);
        bus_write(8'h00, 8'h0F);

        // Asynchronous reset in the middle of a packet.
        clear_stats();
        send_pkt(0, 0, 4, 16'hE000, 16'h0001, 1'b1);
        n = 0;
        while (beats[0] < 1 && n < 50) begin @(posedge clk); n++; end
        check_eq("t6_started", beats[0] >= 1, 1'b1);
        bus_write(8'h00, 8'h03);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check_eq("t6_rst_tvalid", egress_tvalid[0], 1'b0);
        check_eq("t6_rst_tready", ingress_tready[0], 1'b0);
        for (int i = 0; i < NI; i++) in_q[i].delete();
        for (int e = 0; e < NE; e++) exp_q[e].delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bus_read(8'h00, rd); check_eq("t6_mask", rd, 8'h0F);
        clear_stats();
        send_pkt(0, 0, 3, 16'hF000, 16'h0001, 1'b1);
        wait_idle(50);
        check_eq("t6_new_beats", beats[0], 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
